// File: rtl/team_07_wb_gpio_bank.sv
// Wishbone-slave GPIO bank: output, output-enable and synchronised input
// registers, per-pin reserved-pin locking, edge-detect status with W1C,
// and a single masked level interrupt.
module team_07_wb_gpio_bank #(
   parameter int unsigned NUM_GPIO  = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] LOCK_MASK = 32'h0000_001E
) (
   input  logic                wb_clk_i,
   input  logic                nrst,
   input  logic                cyc_i,
   input  logic                stb_i,
   input  logic                we_i,
   input  logic [31:0]         adr_i,
   input  logic [3:0]          sel_i,
   input  logic [31:0]         dat_i,
   output logic [31:0]         dat_o,
   output logic                ack_o,
   input  logic [NUM_GPIO-1:0] gpio_in,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic [NUM_GPIO-1:0] gpio_oeb,
   output logic                irq
);

   localparam logic [NUM_GPIO-1:0] LOCK = LOCK_MASK[NUM_GPIO-1:0];

   typedef enum logic [2:0] {
      REG_OUT     = 3'd0,
      REG_OEB     = 3'd1,
      REG_IN      = 3'd2,
      REG_RISE_EN = 3'd3,
      REG_FALL_EN = 3'd4,
      REG_STATUS  = 3'd5,
      REG_IRQ_EN  = 3'd6,
      REG_ID      = 3'd7
   } reg_e;

   logic [NUM_GPIO-1:0] out_r, oeb_r, rise_en_r, fall_en_r, status_r;
   logic [NUM_GPIO-1:0] s1_r, s2_r, prev_r;
   logic                irq_en_r;

   logic                req, hit, wr_go, rd_go;
   reg_e                reg_sel;
   logic [31:0]         byte_mask;
   logic [NUM_GPIO-1:0] wmask, wdata, set_vec;
   logic [31:0]         rdata;
   logic                unused_bits;

   assign req     = cyc_i & stb_i & ~ack_o;
   assign hit     = (adr_i[31:5] == BASE_ADDR[31:5]);
   assign wr_go   = req & we_i & hit;
   assign rd_go   = req & ~we_i & hit;
   assign reg_sel = reg_e'(adr_i[4:2]);

   // Expand byte-lane selects into a bit mask clipped to the pin count
   always_comb begin
      byte_mask = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         byte_mask[b*8 +: 8] = {8{sel_i[b]}};
      end
      wmask = byte_mask[NUM_GPIO-1:0];
      wdata = dat_i[NUM_GPIO-1:0];
   end

   // Qualified edges from the synchronised input; reserved pins never set status
   assign set_vec = ((s2_r & ~prev_r & rise_en_r) | (~s2_r & prev_r & fall_en_r)) & ~LOCK;

   // Read multiplexer; bits above NUM_GPIO stay zero
   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         REG_OUT:     rdata[NUM_GPIO-1:0] = out_r;
         REG_OEB:     rdata[NUM_GPIO-1:0] = oeb_r;
         REG_IN:      rdata[NUM_GPIO-1:0] = s2_r;
         REG_RISE_EN: rdata[NUM_GPIO-1:0] = rise_en_r;
         REG_FALL_EN: rdata[NUM_GPIO-1:0] = fall_en_r;
         REG_STATUS:  rdata[NUM_GPIO-1:0] = status_r;
         REG_IRQ_EN:  rdata[0]            = irq_en_r;
         REG_ID:      rdata               = {16'h0007, 8'(NUM_GPIO), 8'h02};
         default:     rdata               = '0;
      endcase
   end

   // Bus handshake, register writes, input synchronisation and status update
   always_ff @(posedge wb_clk_i) begin
      if (!nrst) begin
         ack_o     <= 1'b0;
         dat_o     <= '0;
         out_r     <= '0;
         oeb_r     <= '1;
         rise_en_r <= '0;
         fall_en_r <= '0;
         status_r  <= '0;
         irq_en_r  <= 1'b0;
         s1_r      <= '0;
         s2_r      <= '0;
         prev_r    <= '0;
      end else begin
         ack_o  <= req;
         dat_o  <= rd_go ? rdata : '0;
         s1_r   <= gpio_in;
         s2_r   <= s1_r;
         prev_r <= s2_r;

         if (wr_go) begin
            unique case (reg_sel)
               REG_OUT:     out_r     <= (out_r & ~wmask) | (wdata & wmask);
               REG_OEB:     oeb_r     <= (oeb_r & ~wmask) | (wdata & wmask);
               REG_RISE_EN: rise_en_r <= (rise_en_r & ~wmask) | (wdata & wmask);
               REG_FALL_EN: fall_en_r <= (fall_en_r & ~wmask) | (wdata & wmask);
               REG_IRQ_EN:  if (sel_i[0]) irq_en_r <= dat_i[0];
               default:     ;
            endcase
         end

         // Set is OR-ed in after the clear so a coincident edge keeps the bit
         if (wr_go && reg_sel == REG_STATUS)
            status_r <= (status_r & ~(wdata & wmask)) | set_vec;
         else
            status_r <= status_r | set_vec;
      end
   end

   assign gpio_out = out_r & ~LOCK;
   assign gpio_oeb = oeb_r | LOCK;
   assign irq      = irq_en_r & (|(status_r & ~LOCK));

   assign unused_bits = &{1'b0, adr_i[1:0], dat_i};

endmodule
